// File: rtl/memory_wr_front.sv
// Write-side front end for the DE0 dual-clock memory: synchronises and debounces the
// write key, captures the switch byte and issues single-cycle write strobes unless full.
module memory_wr_front #(
  parameter int DATA_W = 8,
  parameter int DB_CYC = 4,
  parameter int CNT_W  = 8
) (
  input  logic              w_clk,
  input  logic              n_rst,
  input  logic              key_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              full,
  output logic [DATA_W-1:0] din,
  output logic              din_vld,
  output logic              wr_drop,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              busy
);

  localparam int DB_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS_DB = 2'd1,
    S_HELD     = 2'd2,
    S_REL_DB   = 2'd3
  } state_t;

  state_t            state_r;
  logic [DB_W-1:0]   cnt_r;
  logic [1:0]        key_sync_r;
  logic [DATA_W-1:0] sw_meta_r;
  logic [DATA_W-1:0] sw_sync_r;
  logic              key_s;
  logic [DATA_W-1:0] sw_s;

  assign key_s = key_sync_r[1];
  assign sw_s  = sw_sync_r;

  // Two-flop synchronisers; the key resets to the released level.
  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      key_sync_r <= 2'b11;
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
    end else begin
      key_sync_r <= {key_sync_r[0], key_n};
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
    end
  end

  // Debounce FSM with registered write strobe, drop pulse, counter and busy flag.
  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      din     <= '0;
      din_vld <= 1'b0;
      wr_drop <= 1'b0;
      wr_cnt  <= '0;
      busy    <= 1'b0;
    end else begin
      din_vld <= 1'b0;
      wr_drop <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (!key_s) begin
            state_r <= S_PRESS_DB;
            cnt_r   <= '0;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        S_PRESS_DB: begin
          if (key_s) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end else if (cnt_r == DB_LAST) begin
            // Only the full flag at this edge decides between write and drop.
            state_r <= S_HELD;
            cnt_r   <= '0;
            if (full) begin
              wr_drop <= 1'b1;
            end else begin
              din     <= sw_s;
              din_vld <= 1'b1;
              wr_cnt  <= wr_cnt + CNT_W'(1);
            end
          end else begin
            cnt_r   <= cnt_r + DB_W'(1);
          end
        end
        S_HELD: begin
          if (key_s) begin
            state_r <= S_REL_DB;
            cnt_r   <= '0;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        S_REL_DB: begin
          if (!key_s) begin
            state_r <= S_HELD;
            cnt_r   <= '0;
          end else if (cnt_r == DB_LAST) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + DB_W'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_wr_front.sv
// Randomised self-checking bench for memory_wr_front against a run-length reference
// model of the debounced key (armed / disarmed with low and high stable-run counts).
module tb_memory_wr_front;

  localparam int DATA_W = 8;
  localparam int DB_CYC = 4;
  localparam int CNT_W  = 8;

  logic              w_clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              key_n = 1'b1;
  logic [DATA_W-1:0] sw    = '0;
  logic              full  = 1'b0;
  logic [DATA_W-1:0] din;
  logic              din_vld;
  logic              wr_drop;
  logic [CNT_W-1:0]  wr_cnt;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  memory_wr_front #(.DATA_W(DATA_W), .DB_CYC(DB_CYC), .CNT_W(CNT_W)) dut (
    .w_clk(w_clk), .n_rst(n_rst), .key_n(key_n), .sw(sw), .full(full),
    .din(din), .din_vld(din_vld), .wr_drop(wr_drop), .wr_cnt(wr_cnt), .busy(busy)
  );

  always #5 w_clk = ~w_clk;

  // Reference model: a press counts once the synchronised key has been low for
  // DB_CYC+1 consecutive samples while armed; re-arming needs DB_CYC+1 high samples.
  bit                armed;
  int                low_run, high_run;
  logic              mk1, mk2;
  logic [DATA_W-1:0] ms1, ms2;
  logic [DATA_W-1:0] e_din;
  logic [CNT_W-1:0]  e_cnt;
  logic              e_vld, e_drop, e_busy;

  int bad, bad_cyc, vld_seen, drop_seen, last_vld_cyc, cyc;
  logic [DATA_W-1:0] last_din;
  logic [18:0] act, expv, bad_act, bad_exp;

  task automatic model_reset();
    armed = 1'b1; low_run = 0; high_run = 0;
    mk1 = 1'b1; mk2 = 1'b1; ms1 = '0; ms2 = '0;
    e_din = '0; e_cnt = '0; e_vld = 1'b0; e_drop = 1'b0; e_busy = 1'b0;
  endtask

  task automatic clear_stats();
    bad = 0; bad_cyc = 0; vld_seen = 0; drop_seen = 0; last_vld_cyc = 0; cyc = 0;
    last_din = '0; bad_act = '0; bad_exp = '0;
  endtask

  task automatic step();
    logic ks;
    logic [DATA_W-1:0] ss;
    @(posedge w_clk);
    if (n_rst) begin
      ks = mk2; ss = ms2;
      e_vld = 1'b0; e_drop = 1'b0;
      if (armed) begin
        if (!ks) begin
          low_run++;
          if (low_run == DB_CYC + 1) begin
            armed = 1'b0; high_run = 0; low_run = 0;
            if (full) e_drop = 1'b1;
            else begin e_vld = 1'b1; e_din = ss; e_cnt = e_cnt + 8'd1; end
          end
        end else low_run = 0;
      end else begin
        if (ks) begin
          high_run++;
          if (high_run == DB_CYC + 1) begin armed = 1'b1; low_run = 0; high_run = 0; end
        end else high_run = 0;
      end
      e_busy = !armed || (low_run > 0);
      mk2 = mk1; mk1 = key_n; ms2 = ms1; ms1 = sw;
    end
    #1;
    cyc++;
    act  = {din_vld, wr_drop, busy, wr_cnt, din};
    expv = {e_vld, e_drop, e_busy, e_cnt, e_din};
    if (act !== expv) begin
      if (bad == 0) begin bad_act = act; bad_exp = expv; bad_cyc = cyc; end
      bad++;
    end
    if (din_vld === 1'b1) begin vld_seen++; last_vld_cyc = cyc; last_din = din; end
    if (wr_drop === 1'b1) drop_seen++;
  endtask

  task automatic press(input logic [DATA_W-1:0] v, input int lo, input int hi);
    sw = v; key_n = 1'b0;
    repeat (lo) step();
    key_n = 1'b1;
    repeat (hi) step();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    model_reset();
    clear_stats();
    #3;
    n_cmp++;
    if ({din_vld, wr_drop, busy, wr_cnt, din} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_values: got %h want 0", {din_vld, wr_drop, busy, wr_cnt, din});
    end
    @(negedge w_clk);
    n_rst = 1'b1;
  endtask

  task automatic test_single_press();
    clear_stats();
    sw = 8'h89; full = 1'b0; key_n = 1'b0;
    repeat (20) step();
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL single_model: cyc %0d got %h want %h", bad_cyc, bad_act, bad_exp); end
    n_cmp++;
    if (vld_seen != 1 || last_vld_cyc != DB_CYC + 3) begin
      n_err++; $display("FAIL single_latency: got %0d strobes at cycle %0d want 1 at %0d", vld_seen, last_vld_cyc, DB_CYC + 3);
    end
    n_cmp++;
    if (last_din !== 8'h89 || wr_cnt !== 8'd1) begin
      n_err++; $display("FAIL single_data: got din %h cnt %0d want 89 / 1", last_din, wr_cnt);
    end
    key_n = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (busy !== 1'b0 || vld_seen != 1) begin
      n_err++; $display("FAIL single_release: got busy %b strobes %0d want 0 / 1", busy, vld_seen);
    end
  endtask

  task automatic test_bounce();
    logic [1:0] pat [5] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    logic [CNT_W-1:0] c0;
    clear_stats();
    c0 = e_cnt;
    sw = 8'($urandom);
    for (int i = 0; i < 5; i++) begin key_n = pat[i][0]; step(); end
    key_n = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (bad != 0 || vld_seen != 0 || busy !== 1'b0 || wr_cnt !== c0) begin
      n_err++; $display("FAIL bounce: strobes %0d busy %b cnt %0d want 0 / 0 / %0d (model diff %h vs %h)", vld_seen, busy, wr_cnt, c0, bad_act, bad_exp);
    end
  endtask

  task automatic test_three_writes();
    logic [DATA_W-1:0] vals [3] = '{8'hFE, 8'h98, 8'h12};
    logic [CNT_W-1:0] c0;
    c0 = e_cnt;
    for (int i = 0; i < 3; i++) begin
      clear_stats();
      press(vals[i], 12, 10);
      n_cmp++;
      if (bad != 0 || vld_seen != 1 || last_din !== vals[i]) begin
        n_err++; $display("FAIL three_writes[%0d]: got %0d strobes din %h want 1 / %h", i, vld_seen, last_din, vals[i]);
      end
    end
    n_cmp++;
    if (wr_cnt !== c0 + 8'd3) begin n_err++; $display("FAIL three_count: got %0d want %0d", wr_cnt, c0 + 8'd3); end
  endtask

  task automatic test_full_drop();
    logic [CNT_W-1:0] c0;
    c0 = e_cnt;
    clear_stats();
    full = 1'b1;
    press(8'h55, 12, 10);
    n_cmp++;
    if (bad != 0 || drop_seen != 1 || vld_seen != 0 || din !== 8'h12 || wr_cnt !== c0) begin
      n_err++; $display("FAIL full_drop: drops %0d strobes %0d din %h cnt %0d want 1 / 0 / 12 / %0d", drop_seen, vld_seen, din, wr_cnt, c0);
    end
    clear_stats();
    full = 1'b0;
    press(8'h55, 12, 10);
    n_cmp++;
    if (bad != 0 || vld_seen != 1 || drop_seen != 0 || last_din !== 8'h55 || wr_cnt !== c0 + 8'd1) begin
      n_err++; $display("FAIL full_retry: strobes %0d din %h cnt %0d want 1 / 55 / %0d", vld_seen, last_din, wr_cnt, c0 + 8'd1);
    end
  endtask

  task automatic test_release_bounce();
    clear_stats();
    sw = 8'($urandom);
    key_n = 1'b0; repeat (12) step();
    key_n = 1'b1; step();
    key_n = 1'b0; step();
    key_n = 1'b1; repeat (10) step();
    n_cmp++;
    if (bad != 0 || vld_seen != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL release_bounce: strobes %0d busy %b want 1 / 0 (model diff %h vs %h)", vld_seen, busy, bad_act, bad_exp);
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    sw = 8'hA7;
    key_n = 1'b0;
    repeat (4) step();
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({din_vld, wr_drop, busy, wr_cnt, din} !== 19'd0) begin
      n_err++; $display("FAIL reset_mid: got %h want 0", {din_vld, wr_drop, busy, wr_cnt, din});
    end
    repeat (3) step();
    @(negedge w_clk);
    n_rst = 1'b1;
    clear_stats();
    repeat (12) step();
    n_cmp++;
    if (bad != 0 || vld_seen != 1 || last_vld_cyc != DB_CYC + 3 || last_din !== 8'hA7 || wr_cnt !== 8'd1) begin
      n_err++; $display("FAIL held_through_reset: strobes %0d at %0d din %h cnt %0d want 1 at %0d / a7 / 1", vld_seen, last_vld_cyc, last_din, wr_cnt, DB_CYC + 3);
    end
    key_n = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_wrap();
    clear_stats();
    full = 1'b0;
    while (e_cnt != 8'hFF) press(8'($urandom), 8, 8);
    n_cmp++;
    if (bad != 0 || wr_cnt !== 8'hFF) begin n_err++; $display("FAIL wrap_preload: got %0d want 255", wr_cnt); end
    press(8'h3C, 8, 8);
    n_cmp++;
    if (bad != 0 || wr_cnt !== 8'h00 || last_din !== 8'h3C) begin
      n_err++; $display("FAIL wrap: got cnt %0d din %h want 0 / 3c", wr_cnt, last_din);
    end
  endtask

  task automatic test_random();
    int run;
    clear_stats();
    run = 0;
    for (int i = 0; i < 2000; i++) begin
      if (run == 0) begin
        key_n = ~key_n;
        run = $urandom_range(1, 9);
        full = ($urandom_range(0, 3) == 0);
      end
      run--;
      if ($urandom_range(0, 2) == 0) sw = 8'($urandom);
      step();
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL random_model: %0d bad cycles, first %0d got %h want %h", bad, bad_cyc, bad_act, bad_exp); end
    n_cmp++;
    if (vld_seen == 0 || drop_seen == 0) begin
      n_err++; $display("FAIL random_activity: got %0d writes %0d drops want both nonzero", vld_seen, drop_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_three_writes();
    test_full_drop();
    test_release_bounce();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
